// File: rtl/viterbi_pkg.sv
// Shared types and the generator definition for the K=3, rate-1/2 convolutional codec.
package viterbi_pkg;

    localparam int NUM_STATES = 4;

    // Encoder state {u(k-1), u(k-2)}.
    typedef logic [1:0] state_t;

    // Generators 7 (c1) and 5 (c0), returned as {c1,c0}.
    function automatic logic [1:0] expected_sym(input state_t s, input logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select and register-exchange path update for one trellis state {u,a}.
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int     SURV_LEN = 16,
    parameter int     PM_W     = 7,
    parameter state_t STATE    = 2'd0
) (
    input  logic [PM_W-1:0]     pm_a,
    input  logic [PM_W-1:0]     pm_b,
    input  logic [SURV_LEN-1:0] path_a,
    input  logic [SURV_LEN-1:0] path_b,
    input  logic [1:0]          sym,
    output logic [PM_W-1:0]     pm_new,
    output logic [SURV_LEN-1:0] path_new
);

    // Predecessor a is {STATE[0],0}, predecessor b is {STATE[0],1}; both emit input u = STATE[1].
    localparam logic   U      = STATE[1];
    localparam state_t PRED_A = {STATE[0], 1'b0};
    localparam state_t PRED_B = {STATE[0], 1'b1};

    logic [1:0]          diff_a;
    logic [1:0]          diff_b;
    logic [PM_W-1:0]     cand_a;
    logic [PM_W-1:0]     cand_b;
    logic [SURV_LEN-1:0] path_sel;

    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        diff_a   = sym ^ expected_sym(PRED_A, U);
        diff_b   = sym ^ expected_sym(PRED_B, U);
        cand_a   = pm_a + PM_W'(diff_a[1]) + PM_W'(diff_a[0]);
        cand_b   = pm_b + PM_W'(diff_b[1]) + PM_W'(diff_b[0]);
        pm_new   = cand_a;
        path_sel = path_a;
        // Ties keep the predecessor with s0=0.
        if (cand_b < cand_a) begin
            pm_new   = cand_b;
            path_sel = path_b;
        end
        path_new = (path_sel << 1) | SURV_LEN'(U);
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision 4-state Viterbi decoder: four ACS units, metric normaliser, best-state output.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int SURV_LEN = 16,
    parameter int PM_W     = 7,
    parameter int PM_INIT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] sym,
    output logic       d_out
);

    logic [PM_W-1:0]     pm        [NUM_STATES];
    logic [SURV_LEN-1:0] path      [NUM_STATES];
    logic [PM_W-1:0]     cand_pm   [NUM_STATES];
    logic [SURV_LEN-1:0] cand_path [NUM_STATES];
    logic [PM_W-1:0]     pm_min;
    state_t              best;

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam int PA = 2 * (g % 2);
        acs_unit #(
            .SURV_LEN (SURV_LEN),
            .PM_W     (PM_W),
            .STATE    (state_t'(g))
        ) u_acs (
            .pm_a     (pm[PA]),
            .pm_b     (pm[PA+1]),
            .path_a   (path[PA]),
            .path_b   (path[PA+1]),
            .sym      (sym),
            .pm_new   (cand_pm[g]),
            .path_new (cand_path[g])
        );
    end

    // Normalise against the old minimum; pick the lowest-index state holding the smallest new metric.
    always_comb begin
        pm_min = pm[0];
        best   = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm[i] < pm_min) pm_min = pm[i];
            if (cand_pm[i] < cand_pm[best]) best = state_t'(i);
        end
    end

    // NOTE: survivor paths are reset rather than left undefined; their zero fill is the warm-up output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= PM_W'(i == 0 ? 0 : PM_INIT);
                path[i] <= '0;
            end
            d_out <= 1'b0;
        end else if (enable) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= cand_pm[i] - pm_min;
                path[i] <= cand_path[i];
            end
            d_out <= cand_path[best][SURV_LEN-1];
        end
    end

endmodule

// File: rtl/viterbi_encoder.sv
// Rate-1/2 convolutional encoder: two-bit input shift register plus the generator taps.
module viterbi_encoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       d_in,
    output logic       valid,
    output logic [1:0] d_out
);

    state_t s;

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            valid <= 1'b0;
            d_out <= '0;
        end else if (enable) begin
            d_out <= expected_sym(s, d_in);
            valid <= 1'b1;
            s     <= {d_in, s[1]};
        end else begin
            valid <= 1'b0;
            d_out <= '0;
        end
    end

endmodule

// File: rtl/viterbi_codec.sv
// Codec core: independent encoder and decoder halves sharing only clock and reset.
module viterbi_codec #(
    parameter int SURV_LEN = 16,
    parameter int PM_W     = 7,
    parameter int PM_INIT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_in,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_out,
    input  logic       dec_enable,
    input  logic [1:0] dec_d_in,
    output logic       dec_d_out
);

    viterbi_encoder u_enc (
        .clk    (clk),
        .rst    (rst),
        .enable (enc_enable_i),
        .d_in   (enc_d_in),
        .valid  (enc_valid_o),
        .d_out  (enc_d_out)
    );

    viterbi_decoder #(
        .SURV_LEN (SURV_LEN),
        .PM_W     (PM_W),
        .PM_INIT  (PM_INIT)
    ) u_dec (
        .clk    (clk),
        .rst    (rst),
        .enable (dec_enable),
        .sym    (dec_d_in),
        .d_out  (dec_d_out)
    );

endmodule

// File: tb/tb_viterbi_codec.sv
// Scoreboard bench: encoder looped into decoder through a bench channel, checked against a bit-stream model.
module tb_viterbi_codec;

    localparam int SURV_LEN = 16;
    localparam int DELAY    = SURV_LEN - 1;
    localparam int N_BITS   = 256;
    localparam int RESYNC   = 8;

    typedef struct {
        bit val;
        bit known;
    } dexp_t;

    logic        clk;
    logic        rst;
    logic        enc_enable_i;
    logic        enc_d_in;
    logic        enc_valid_o;
    logic [1:0]  enc_d_out;
    logic        dec_enable;
    logic [1:0]  dec_d_in;
    logic        dec_d_out;

    logic [1:0]  held;
    logic [1:0]  flip;
    logic [31:0] enc_sym_cnt;
    bit          err_mode;
    bit          force_11;

    int          total;
    int          bad;
    logic [1:0]  enc_exp_q [$];
    dexp_t       dec_exp_q [$];
    bit          ref_bits  [$];
    bit          ref_known [$];
    bit          enc_hist  [$];
    bit          stream    [N_BITS];

    viterbi_codec #(
        .SURV_LEN (SURV_LEN),
        .PM_W     (7),
        .PM_INIT  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_in     (enc_d_in),
        .enc_valid_o  (enc_valid_o),
        .enc_d_out    (enc_d_out),
        .dec_enable   (dec_enable),
        .dec_d_in     (dec_d_in),
        .dec_d_out    (dec_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel: optional double-bit error on every symbol with index mod 16 = 15, hold during gaps, forced 11 override.
    assign flip       = (err_mode && enc_sym_cnt[3:0] == 4'd15) ? 2'b11 : 2'b00;
    assign dec_enable = force_11 | enc_valid_o;
    assign dec_d_in   = force_11 ? 2'b11 : (enc_valid_o ? (enc_d_out ^ flip) : held);

    always @(posedge clk) begin
        if (rst) begin
            enc_sym_cnt <= '0;
            held        <= '0;
        end else if (enc_valid_o) begin
            enc_sym_cnt <= enc_sym_cnt + 1;
            held        <= enc_d_out ^ flip;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Generator polynomials 7 and 5 applied to the history of bits since reset.
    task automatic enc_model(input bit u, output logic [1:0] sym);
        bit h1;
        bit h2;
        int n;
        n  = enc_hist.size();
        h1 = (n > 0) ? enc_hist[n-1] : 1'b0;
        h2 = (n > 1) ? enc_hist[n-2] : 1'b0;
        sym = {u ^ h1 ^ h2, u ^ h2};
        enc_hist.push_back(u);
    endtask

    // Decoded output after accepting symbol k is bit k-DELAY, or 0 before that bit exists.
    task automatic push_dec_exp(input bit u, input bit known);
        int    k;
        dexp_t e;
        k = ref_bits.size();
        ref_bits.push_back(u);
        ref_known.push_back(known);
        if (k < DELAY) begin
            e.val   = 1'b0;
            e.known = 1'b1;
        end else begin
            e.val   = ref_bits[k-DELAY];
            e.known = ref_known[k-DELAY];
        end
        dec_exp_q.push_back(e);
    endtask

    task automatic send_bit(input bit u, input bit known, input bit use_lit, input logic [1:0] lit);
        logic [1:0] s;
        enc_model(u, s);
        enc_exp_q.push_back(use_lit ? lit : s);
        push_dec_exp(u, known);
        enc_enable_i = 1'b1;
        enc_d_in     = u;
        @(posedge clk);
        #1;
        enc_enable_i = 1'b0;
        enc_d_in     = 1'b0;
    endtask

    task automatic idle_cycle();
        enc_enable_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic force_sym();
        force_11 = 1'b1;
        push_dec_exp(1'b0, 1'b0);
        @(posedge clk);
        #1;
        force_11 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((enc_exp_q.size() + dec_exp_q.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", enc_exp_q.size() + dec_exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        enc_enable_i = 1'b0;
        enc_d_in     = 1'b0;
        err_mode     = 1'b0;
        force_11     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enc_exp_q.delete();
        dec_exp_q.delete();
        ref_bits.delete();
        ref_known.delete();
        enc_hist.delete();
        @(negedge clk);
        check("rst_enc_valid", enc_valid_o, 0);
        check("rst_enc_d_out", enc_d_out, 0);
        check("rst_dec_d_out", dec_d_out, 0);
        @(posedge clk);
        #1;
    endtask

    // Encoder monitor.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (enc_valid_o === 1'b1) begin
                if (enc_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL enc_extra: got symbol %b, expected none", enc_d_out);
                end else begin
                    e = enc_exp_q.pop_front();
                    check("enc_sym", enc_d_out, e);
                end
            end else begin
                check("enc_idle", {enc_valid_o, enc_d_out}, 0);
            end
        end
    end

    // Decoder monitor: one comparison per accepted symbol, hold check on every gap cycle.
    initial begin
        bit    pend_en;
        bit    pend_rst;
        logic  prev;
        dexp_t e;
        pend_en  = 1'b0;
        pend_rst = 1'b1;
        prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (!pend_rst) begin
                if (pend_en) begin
                    if (dec_exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dec_extra: got %b, expected no accepted symbol", dec_d_out);
                    end else begin
                        e = dec_exp_q.pop_front();
                        if (e.known) check("dec_bit", dec_d_out, e.val);
                        else         check("dec_defined", $isunknown(dec_d_out), 0);
                    end
                end else begin
                    check("dec_hold", dec_d_out, prev);
                end
            end
            prev     = dec_d_out;
            pend_en  = dec_enable;
            pend_rst = rst;
        end
    end

    initial begin
        logic [1:0] lit   [6];
        bit         lit_u [6];
        int         idx;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        enc_enable_i = 1'b0;
        enc_d_in     = 1'b0;
        err_mode     = 1'b0;
        force_11     = 1'b0;
        lit   = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        lit_u = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < N_BITS; i++) stream[i] = 1'($urandom_range(1));

        // Directed encoder vector.
        do_reset();
        for (int i = 0; i < 6; i++) send_bit(lit_u[i], 1'b1, 1'b1, lit[i]);
        drain();

        // Clean loop-back.
        do_reset();
        for (int i = 0; i < N_BITS; i++) send_bit(stream[i], 1'b1, 1'b0, 2'b00);
        drain();

        // Double-bit error on every 16th symbol.
        do_reset();
        err_mode = 1'b1;
        for (int i = 0; i < N_BITS; i++) send_bit(stream[i], 1'b1, 1'b0, 2'b00);
        drain();
        err_mode = 1'b0;

        // Random gaps in the symbol stream.
        do_reset();
        idx = 0;
        while (idx < N_BITS) begin
            if ($urandom_range(1) == 1) begin
                send_bit(stream[idx], 1'b1, 1'b0, 2'b00);
                idx++;
            end else begin
                idle_cycle();
            end
        end
        drain();

        // Worst-case metric growth, then a clean stream the decoder must lock onto.
        do_reset();
        repeat (2000) force_sym();
        for (int i = 0; i < 200; i++) send_bit(stream[i], i >= RESYNC, 1'b0, 2'b00);
        drain();

        // Mid-stream reset, then a fresh sequence.
        do_reset();
        for (int i = 0; i < 40; i++) send_bit(stream[N_BITS-1-i], 1'b1, 1'b0, 2'b00);
        do_reset();
        for (int i = 0; i < N_BITS; i++) send_bit(stream[i], 1'b1, 1'b0, 2'b00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
